// File: rtl/key_pkg.sv
// Shared types and defaults for the multi-channel key debouncer.
// Imported by key_chan and key_debouncer.
package key_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESSED,
        HELD
    } key_state_t;

    localparam int NKEYS_DEF        = 16;
    localparam int CLK_DIV_DEF      = 1_000_000;
    localparam int NSAMP_DEF        = 3;
    localparam int ACTIVE_LOW_DEF   = 1;
    localparam int HOLD_TICKS_DEF   = 50;
    localparam int REPEAT_TICKS_DEF = 10;

    // Bits needed to hold values 0..n-1, never less than one.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/key_chan.sv
// One key channel: synchroniser, sample history, press/hold/repeat FSM.
// All state advances only on tick except the synchroniser.
module key_chan
    import key_pkg::*;
#(
    parameter int NSAMP        = NSAMP_DEF,
    parameter int ACTIVE_LOW   = ACTIVE_LOW_DEF,
    parameter int HOLD_TICKS   = HOLD_TICKS_DEF,
    parameter int REPEAT_TICKS = REPEAT_TICKS_DEF
) (
    input  logic clk,
    input  logic rstn,
    input  logic tick,
    input  logic key_in,
    output logic key_level,
    output logic key_press,
    output logic key_release,
    output logic key_hold,
    output logic key_repeat
);

    localparam int CMAX = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
    localparam int CW   = cnt_width(CMAX + 1);

    localparam logic          RAW_IDLE = (ACTIVE_LOW != 0);
    localparam logic          REP_EN   = (REPEAT_TICKS > 0);
    localparam logic [CW-1:0] HOLD_T   = CW'(HOLD_TICKS);
    localparam logic [CW-1:0] REP_T    = CW'(REPEAT_TICKS);

    logic             sync1, sync2;
    logic             sample;
    logic [NSAMP-1:0] hist, hist_nx;
    logic             all_on, all_off;
    key_state_t       state, state_nx;
    logic [CW-1:0]    cnt, cnt_nx, cnt_inc;
    logic             press_nx, release_nx, hold_nx, repeat_nx;

    assign sample  = sync2 ^ RAW_IDLE;
    assign hist_nx = {hist[NSAMP-2:0], sample};
    assign all_on  = &hist_nx;
    assign all_off = ~|hist_nx;
    assign cnt_inc = cnt + 1'b1;

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        press_nx   = 1'b0;
        release_nx = 1'b0;
        hold_nx    = 1'b0;
        repeat_nx  = 1'b0;
        if (tick) begin
            case (state)
                IDLE: begin
                    if (all_on) begin
                        state_nx = PRESSED;
                        press_nx = 1'b1;
                        cnt_nx   = '0;
                    end
                end
                PRESSED: begin
                    if (all_off) begin
                        state_nx   = IDLE;
                        release_nx = 1'b1;
                        cnt_nx     = '0;
                    end else if (cnt_inc == HOLD_T) begin
                        state_nx = HELD;
                        hold_nx  = 1'b1;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt_inc;
                    end
                end
                HELD: begin
                    if (all_off) begin
                        state_nx   = IDLE;
                        release_nx = 1'b1;
                        cnt_nx     = '0;
                    end else if (REP_EN) begin
                        if (cnt_inc == REP_T) begin
                            repeat_nx = 1'b1;
                            cnt_nx    = '0;
                        end else begin
                            cnt_nx = cnt_inc;
                        end
                    end
                end
                default: begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1       <= RAW_IDLE;
            sync2       <= RAW_IDLE;
            hist        <= '0;
            state       <= IDLE;
            cnt         <= '0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            key_hold    <= 1'b0;
            key_repeat  <= 1'b0;
        end else begin
            sync1       <= key_in;
            sync2       <= sync1;
            if (tick) begin
                hist <= hist_nx;
            end
            state       <= state_nx;
            cnt         <= cnt_nx;
            key_press   <= press_nx;
            key_release <= release_nx;
            key_hold    <= hold_nx;
            key_repeat  <= repeat_nx;
        end
    end

    assign key_level = (state != IDLE);

endmodule

// File: rtl/key_debouncer.sv
// Multi-channel key debouncer: shared sample-tick divider plus
// NKEYS independent key_chan instances.
module key_debouncer
    import key_pkg::*;
#(
    parameter int NKEYS        = NKEYS_DEF,
    parameter int CLK_DIV      = CLK_DIV_DEF,
    parameter int NSAMP        = NSAMP_DEF,
    parameter int ACTIVE_LOW   = ACTIVE_LOW_DEF,
    parameter int HOLD_TICKS   = HOLD_TICKS_DEF,
    parameter int REPEAT_TICKS = REPEAT_TICKS_DEF
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [NKEYS-1:0] key_in,
    output logic [NKEYS-1:0] key_level,
    output logic [NKEYS-1:0] key_press,
    output logic [NKEYS-1:0] key_release,
    output logic [NKEYS-1:0] key_hold,
    output logic [NKEYS-1:0] key_repeat,
    output logic             tick
);

    localparam int            DW       = cnt_width(CLK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            div_cnt <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // With CLK_DIV=1 the counter sits at 0 and tick stays high.
    assign tick = (div_cnt == DIV_LAST);

    for (genvar i = 0; i < NKEYS; i++) begin : g_chan
        key_chan #(
            .NSAMP       (NSAMP),
            .ACTIVE_LOW  (ACTIVE_LOW),
            .HOLD_TICKS  (HOLD_TICKS),
            .REPEAT_TICKS(REPEAT_TICKS)
        ) u_chan (
            .clk        (clk),
            .rstn       (rstn),
            .tick       (tick),
            .key_in     (key_in[i]),
            .key_level  (key_level[i]),
            .key_press  (key_press[i]),
            .key_release(key_release[i]),
            .key_hold   (key_hold[i]),
            .key_repeat (key_repeat[i])
        );
    end

endmodule

// File: tb/tb_key_debouncer.sv
// Bench for key_debouncer: directed scenarios plus random key traffic
// compared every cycle against a run-length based reference model.
module tb_key_debouncer;

    localparam int NK  = 4;
    localparam int DIV = 4;
    localparam int NS  = 3;
    localparam int HT  = 5;
    localparam int RT  = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rstn, rstn0;
    logic [NK-1:0] key_in, lvl, prs, rel, hld, rpt;
    logic          tck;
    logic [0:0]    k0_in, l0, p0, r0, h0, rp0;
    logic          t0;

    key_debouncer #(
        .NKEYS(NK), .CLK_DIV(DIV), .NSAMP(NS), .ACTIVE_LOW(1),
        .HOLD_TICKS(HT), .REPEAT_TICKS(RT)
    ) dut (
        .clk(clk), .rstn(rstn), .key_in(key_in),
        .key_level(lvl), .key_press(prs), .key_release(rel),
        .key_hold(hld), .key_repeat(rpt), .tick(tck)
    );

    key_debouncer #(
        .NKEYS(1), .CLK_DIV(DIV), .NSAMP(NS), .ACTIVE_LOW(1),
        .HOLD_TICKS(HT), .REPEAT_TICKS(0)
    ) dut0 (
        .clk(clk), .rstn(rstn0), .key_in(k0_in),
        .key_level(l0), .key_press(p0), .key_release(r0),
        .key_hold(h0), .key_repeat(rp0), .tick(t0)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: consecutive-sample run lengths and ticks since press
    int            run1[NK], run0[NK], since[NK];
    bit            mlvl[NK];
    bit            s1[NK], s2[NK];
    int            mcnt;
    logic [NK-1:0] e_prs, e_rel, e_hld, e_rpt;

    task automatic model_reset();
        mcnt = 0;
        e_prs = '0; e_rel = '0; e_hld = '0; e_rpt = '0;
        for (int k = 0; k < NK; k++) begin
            run1[k] = 0; run0[k] = 0; since[k] = 0;
            mlvl[k] = 0; s1[k] = 1; s2[k] = 1;
        end
    endtask

    task automatic model_step();
        bit edge_tick;
        bit smp;
        edge_tick = (mcnt == DIV - 1);
        mcnt = (mcnt + 1) % DIV;
        e_prs = '0; e_rel = '0; e_hld = '0; e_rpt = '0;
        for (int k = 0; k < NK; k++) begin
            smp = !s2[k];
            if (edge_tick) begin
                if (smp) begin run1[k]++; run0[k] = 0; end
                else begin run0[k]++; run1[k] = 0; end
                if (!mlvl[k] && run1[k] >= NS) begin
                    mlvl[k] = 1; e_prs[k] = 1; since[k] = 0;
                end else if (mlvl[k] && run0[k] >= NS) begin
                    mlvl[k] = 0; e_rel[k] = 1;
                end else if (mlvl[k]) begin
                    since[k]++;
                    if (since[k] == HT) e_hld[k] = 1;
                    else if (since[k] > HT && ((since[k] - HT) % RT) == 0)
                        e_rpt[k] = 1;
                end
            end
            s2[k] = s1[k];
            s1[k] = key_in[k];
        end
    endtask

    task automatic compare();
        logic [NK-1:0] el;
        for (int k = 0; k < NK; k++) el[k] = mlvl[k];
        check("tick", 32'(tck), 32'(mcnt == DIV - 1));
        check("level", 32'(lvl), 32'(el));
        check("press", 32'(prs), 32'(e_prs));
        check("release", 32'(rel), 32'(e_rel));
        check("hold", 32'(hld), 32'(e_hld));
        check("repeat", 32'(rpt), 32'(e_rpt));
    endtask

    int e;
    int press0_e = -1, hold0_e = -1, press3_e = -1;
    int press2_e = -1, rel2_e = -1;
    int ev1 = 0, hold2 = 0, rel0cnt = 0;
    int rep0_q[$];

    task automatic record();
        if (prs[0] && press0_e < 0) press0_e = e;
        if (hld[0] && hold0_e < 0) hold0_e = e;
        if (rpt[0]) rep0_q.push_back(e);
        if (prs[3] && press3_e < 0) press3_e = e;
        if (prs[2] && press2_e < 0) press2_e = e;
        if (rel[2] && rel2_e < 0) rel2_e = e;
        ev1 += int'(prs[1]) + int'(rel[1]) + int'(hld[1])
             + int'(rpt[1]) + int'(lvl[1]);
        hold2 += int'(hld[2]);
        rel0cnt += int'(rel[0]);
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rstn) model_step();
        else model_reset();
        e++;
        @(negedge clk);
        compare();
        record();
    endtask

    int hold0cnt = 0, rep0cnt = 0;
    always @(negedge clk) begin
        if (rstn0) begin
            hold0cnt += int'(h0[0]);
            rep0cnt += int'(rp0[0]);
        end
    end

    int dur[NK];
    int r0v, r1v;

    initial begin
        rstn = 1'b0;
        rstn0 = 1'b0;
        key_in = '1;
        k0_in = 1'b0;
        model_reset();
        e = -10;
        repeat (2) cycle();

        // Directed scenarios from a fresh reset
        rstn = 1'b1;
        rstn0 = 1'b1;
        e = -1;
        for (int n = 0; n < 60; n++) begin
            key_in[0] = 1'b0;
            key_in[3] = 1'b0;
            key_in[1] = (n < 40) ? (((n / 3) % 2) == 0) : 1'b1;
            key_in[2] = (press2_e >= 0);
            cycle();
        end
        r0v = (rep0_q.size() > 0) ? rep0_q[0] : -1;
        r1v = (rep0_q.size() > 1) ? rep0_q[1] : -1;
        check("k0_press_edge", press0_e, 11);
        check("k0_hold_edge", hold0_e, 31);
        check("k0_repeat1_edge", r0v, 39);
        check("k0_repeat2_edge", r1v, 47);
        check("k0_repeat_count", rep0_q.size(), 3);
        check("k3_same_press", press3_e, press0_e);
        check("k1_bounce_events", ev1, 0);
        check("k2_release_edge", rel2_e, 23);
        check("k2_no_hold", hold2, 0);

        // Reset while key0 is in HELD
        rstn = 1'b0;
        #1;
        check("async_reset", 32'({tck, lvl, prs, rel, hld, rpt}), 0);
        cycle();
        rstn = 1'b1;
        e = -1;
        press0_e = -1;
        rel0cnt = 0;
        for (int n = 0; n < 20; n++) begin
            key_in = 4'b1110;
            cycle();
        end
        check("k0_repress_edge", press0_e, 11);
        check("k0_no_release", rel0cnt, 0);

        // Random traffic with varied stable durations
        for (int k = 0; k < NK; k++) dur[k] = 0;
        for (int n = 0; n < 1500; n++) begin
            for (int k = 0; k < NK; k++) begin
                if (dur[k] == 0) begin
                    key_in[k] = 1'($urandom_range(0, 1));
                    dur[k] = int'($urandom_range(1, 40));
                end
                dur[k]--;
            end
            cycle();
        end

        check("norep_hold_count", hold0cnt, 1);
        check("norep_repeat_count", rep0cnt, 0);
        check("norep_level", 32'(l0), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
